ks_exciter: RTL and testbench
=============================

# ks_exciter

Pluck excitation generator for the Karplus-Strong voice. On a pluck request it emits a burst of scaled pseudo-random noise whose length equals the current string delay. This fills the delay line with one period of noise. Outside a burst it emits silence. It runs in the sample-rate domain and its output is summed into the input of the programmable delay line.

## Interface
Parameters:
- SEED, 24'h5A5A5A, nonzero LFSR reset/seed value.

Ports:
- lrck  input  1  sample clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising lrck.
- pluck  input  1  pluck request, level; a 0->1 transition between consecutive lrck edges starts a burst.
- delay  input  10  burst length in samples, unsigned; latched at burst start.
- amplitude  input  8  burst gain, unsigned, gain = amplitude/256; sampled every cycle.
- out  output  24  signed excitation sample, registered.
- busy  output  1  high while a burst is in progress, registered.

## Operation
- The noise source is a 24-bit Fibonacci LFSR with polynomial x^24+x^23+x^22+x^17+1.
  - It shifts left, and feedback enters bit 0.
  - Reset loads SEED.
  - It advances exactly once per cycle in which a burst sample is produced.
  - It is not reseeded between plucks.
- Noise sample n = LFSR state before the n-th advance, interpreted as signed 24-bit.
- Scaling: the 32-bit signed product noise * {1'b0, amplitude} is formed, and bits [31:8] are taken (arithmetic, truncating). amplitude=0 gives zero samples, but the burst still runs.
- Edge detect: pluck_q is a registered copy of pluck. start = pluck & ~pluck_q.
- FSM:
  - IDLE: out=0, busy=0. start with delay>=1 -> BURST, latch len=delay, count=0. start with delay==0 -> ignored, remain IDLE.
  - BURST: out=scaled sample, busy=1, count increments. After the len-th sample -> IDLE.
  - start during BURST with delay>=1 retriggers: re-latch len, count=0, stay BURST. The LFSR continues without reseed.
  - start during BURST with delay==0 is ignored, and the burst continues.
- Simultaneous last sample and start: start wins, and a new burst begins with no idle gap.
- A change of delay mid-burst has no effect on the current burst.

## Timing
- Reset values: out=0, busy=0, state=IDLE, count=0, pluck_q=0, LFSR=SEED.
- Reset mid-burst aborts the burst on that edge. pluck_q clears, so a pluck held high through reset release starts a burst on the first edge after release.
- Latency: pluck first sampled high at edge k (low at k-1) -> out carries sample 0 and busy=1 after edge k.
- A burst of len L drives samples at edges k..k+L-1. At edge k+L, out=0 and busy=0 (unless retriggered).
- Sample n of a burst uses the amplitude sampled at the same edge.

## Configuration
- KS_EXCITE_LOWPASS_EN defined:
  - out = (s[n] + s[n-1]) >>> 1, computed on 25-bit sign-extended scaled samples and truncated to 24 bits.
  - s[-1] = 0 at every burst start, including a retrigger.
  - Latency and busy timing are unchanged.
  - This produces a softer, duller pluck.
- KS_EXCITE_LOWPASS_EN undefined: out = s[n] directly, and the history register is not built.

## Test plan
- Reset, then pluck 0->1 with delay=5, amplitude=128 -> sample 0 = 24'h2D2D2D. busy high exactly 5 edges, then out=0 and busy=0.
- Same stimulus with KS_EXCITE_LOWPASS_EN -> sample 0 = 24'h169696. The burst is still exactly 5 samples.
- delay=0 with pluck edge -> busy stays 0, out stays 0, and the LFSR does not advance (the next valid burst's sample 0 at amplitude=128 = 24'h2D2D2D).
- Burst delay=100 retriggered at sample 40 with delay=10 -> busy continuous. Ends 10 samples after the retrigger edge, for 50 samples total. The LFSR sequence is continuous.
- Reset asserted at sample 3 of a delay=20 burst -> out=0 and busy=0 on that edge. After release with pluck held high, a burst starts on the first edge and sample 0 = scaled SEED.
- pluck held high for 200 cycles with delay=8 -> exactly one 8-sample burst. amplitude=0 -> 8 cycles of busy=1 with out=0.

Source files
------------

// File: rtl/ks_exciter.sv
// Karplus-Strong pluck exciter: emits one delay-length burst of scaled LFSR noise per pluck edge.
// Optional two-tap smoothing of the burst is enabled by defining KS_EXCITE_LOWPASS_EN.
module ks_exciter #(
  parameter logic [23:0] SEED = 24'h5A5A5A
) (
  input  logic        lrck,
  input  logic        rst_n,
  input  logic        pluck,
  input  logic [9:0]  delay,
  input  logic [7:0]  amplitude,
  output logic [23:0] out,
  output logic        busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t      state_reg;
  logic [9:0]  len_reg;
  logic [9:0]  count_reg;
  logic [23:0] lfsr_reg;
  logic        pluck_q_reg;
  logic [23:0] out_reg;
  logic        busy_reg;

  // Feedback taps for x^24+x^23+x^22+x^17+1, stored as bit positions
  localparam logic [19:0] TAPS = {5'd16, 5'd21, 5'd22, 5'd23};

  logic [3:0] tap_bits;
  logic       feedback;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_tap
      assign tap_bits[gi] = lfsr_reg[TAPS[gi*5 +: 5]];
    end
  endgenerate

  assign feedback = ^tap_bits;

  logic        start;
  logic        start_valid;
  logic        emit;
  logic [9:0]  len_eff;
  logic [9:0]  count_base;
  logic [9:0]  count_next;
  logic        last;

  assign start       = pluck & ~pluck_q_reg;
  assign start_valid = start && (delay != 10'd0);
  assign emit        = start_valid || (state_reg == BURST);
  assign len_eff     = start_valid ? delay : len_reg;
  assign count_base  = start_valid ? 10'd0 : count_reg;
  assign count_next  = count_base + 10'd1;
  assign last        = (count_next == len_eff);

  // Product magnitude stays below 2^31, so 32 bits hold it exactly
  logic signed [31:0] prod;
  logic [23:0]        scaled;
  logic [23:0]        sample;

  assign prod   = $signed({{8{lfsr_reg[23]}}, lfsr_reg}) * $signed({24'd0, amplitude});
  assign scaled = prod[31:8];

`ifdef KS_EXCITE_LOWPASS_EN
  logic [23:0] hist_reg;
  logic [23:0] prev_eff;
  logic [24:0] sum25;
  logic        unused_bits;

  // History restarts from zero on every burst start, retriggers included
  assign prev_eff    = start_valid ? 24'd0 : hist_reg;
  assign sum25       = {scaled[23], scaled} + {prev_eff[23], prev_eff};
  assign sample      = sum25[24:1];
  assign unused_bits = ^{prod[7:0], sum25[0]};

  always_ff @(posedge lrck) begin
    if (!rst_n) begin
      hist_reg <= 24'd0;
    end else if (emit) begin
      hist_reg <= scaled;
    end
  end
`else
  logic unused_bits;

  assign sample      = scaled;
  assign unused_bits = ^prod[7:0];
`endif

  always_ff @(posedge lrck) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      len_reg     <= 10'd0;
      count_reg   <= 10'd0;
      lfsr_reg    <= SEED;
      pluck_q_reg <= 1'b0;
      out_reg     <= 24'd0;
      busy_reg    <= 1'b0;
    end else begin
      pluck_q_reg <= pluck;
      if (emit) begin
        out_reg   <= sample;
        busy_reg  <= 1'b1;
        lfsr_reg  <= {lfsr_reg[22:0], feedback};
        if (start_valid) begin
          len_reg <= delay;
        end
        // Leaving BURST on the last sample lets a start on the next edge follow without a gap
        if (last) begin
          state_reg <= IDLE;
          count_reg <= 10'd0;
        end else begin
          state_reg <= BURST;
          count_reg <= count_next;
        end
      end else begin
        out_reg   <= 24'd0;
        busy_reg  <= 1'b0;
        state_reg <= IDLE;
        count_reg <= 10'd0;
      end
    end
  end

  assign out  = out_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_ks_exciter.sv
// Directed bench for ks_exciter: hand-computed vector table plus model-checked multi-cycle sequences.
module tb_ks_exciter;

  localparam logic [23:0] SEED = 24'h5A5A5A;

  logic        lrck;
  logic        rst_n;
  logic        pluck;
  logic [9:0]  delay;
  logic [7:0]  amplitude;
  logic [23:0] out;
  logic        busy;

  ks_exciter #(.SEED(SEED)) dut (
    .lrck      (lrck),
    .rst_n     (rst_n),
    .pluck     (pluck),
    .delay     (delay),
    .amplitude (amplitude),
    .out       (out),
    .busy      (busy)
  );

  initial lrck = 1'b0;
  always #5 lrck = ~lrck;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic        m_pq;
  int          m_rem;
  logic [23:0] m_lfsr;
  logic [23:0] m_prev;
  logic [23:0] exp_out;
  logic        exp_busy;

  typedef struct {
    logic        p;
    logic [9:0]  d;
    logic [7:0]  a;
    logic [23:0] eo;
    logic        eb;
  } vec_t;

  vec_t vt[9];

  function automatic logic [23:0] lfsr_step(input logic [23:0] s);
    return {s[22:0], s[23] ^ s[22] ^ s[21] ^ s[16]};
  endfunction

  function automatic logic [23:0] scale(input logic [23:0] n, input logic [7:0] a);
    int          p;
    logic [31:0] t;
    p = int'($signed(n)) * int'(a);
    t = p >>> 8;
    return t[23:0];
  endfunction

  function automatic logic [23:0] smooth(input logic [23:0] s, input logic [23:0] prev);
    int          sum;
    logic [31:0] t;
    sum = int'($signed(s)) + int'($signed(prev));
    t = sum >>> 1;
    return t[23:0];
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic tick(input logic p, input logic [9:0] d, input logic [7:0] a, input logic r);
    logic [23:0] s;
    pluck = p; delay = d; amplitude = a; rst_n = r;
    @(posedge lrck);
    #1;
    if (!r) begin
      m_pq = 1'b0; m_rem = 0; m_lfsr = SEED; m_prev = 24'd0;
      exp_out = 24'd0; exp_busy = 1'b0;
    end else begin
      if (p && !m_pq && d != 10'd0) begin
        m_rem  = int'(d);
        m_prev = 24'd0;
      end
      if (m_rem != 0) begin
        s = scale(m_lfsr, a);
`ifdef KS_EXCITE_LOWPASS_EN
        exp_out = smooth(s, m_prev);
`else
        exp_out = s;
`endif
        m_prev   = s;
        m_lfsr   = lfsr_step(m_lfsr);
        m_rem--;
        exp_busy = 1'b1;
      end else begin
        exp_out  = 24'd0;
        exp_busy = 1'b0;
      end
      m_pq = p;
    end
    $display("tick rst_n=%0b pluck=%0b delay=%0d amp=%0d -> out=%h busy=%0b", r, p, d, a, out, busy);
  endtask

  task automatic tickc(input string tag, input logic p, input logic [9:0] d,
                       input logic [7:0] a, input logic r);
    tick(p, d, a, r);
    check({tag, "_out"}, out, exp_out);
    check({tag, "_busy"}, {23'd0, busy}, {23'd0, exp_busy});
  endtask

  initial begin
    int busy_cnt;
    int nz_cnt;
    logic [23:0] seed0;

    rst_n = 1'b0; pluck = 1'b0; delay = 10'd0; amplitude = 8'd0;
    m_pq = 1'b0; m_rem = 0; m_lfsr = SEED; m_prev = 24'd0;
    exp_out = 24'd0; exp_busy = 1'b0;

    tick(1'b0, 10'd0, 8'd0, 1'b0);
    tick(1'b0, 10'd0, 8'd0, 1'b0);
    check("reset_out", out, 24'd0);
    check("reset_busy", {23'd0, busy}, 24'd0);

    // Hand-derived burst after reset: delay=0 edge ignored, then a 5-sample burst at amp=128
`ifdef KS_EXCITE_LOWPASS_EN
    seed0 = 24'h169696;
    vt[2] = '{1'b1, 10'd5, 8'd128, 24'h169696, 1'b1};
    vt[3] = '{1'b1, 10'd9, 8'd128, 24'h03C3C3, 1'b1};
    vt[4] = '{1'b0, 10'd9, 8'd128, 24'h078787, 1'b1};
    vt[5] = '{1'b0, 10'd9, 8'd128, 24'h0F0F0F, 1'b1};
    vt[6] = '{1'b0, 10'd9, 8'd128, 24'hDE1E1F, 1'b1};
`else
    seed0 = 24'h2D2D2D;
    vt[2] = '{1'b1, 10'd5, 8'd128, 24'h2D2D2D, 1'b1};
    vt[3] = '{1'b1, 10'd9, 8'd128, 24'hDA5A5A, 1'b1};
    vt[4] = '{1'b0, 10'd9, 8'd128, 24'h34B4B5, 1'b1};
    vt[5] = '{1'b0, 10'd9, 8'd128, 24'hE9696A, 1'b1};
    vt[6] = '{1'b0, 10'd9, 8'd128, 24'hD2D2D5, 1'b1};
`endif
    vt[0] = '{1'b1, 10'd0, 8'd128, 24'd0, 1'b0};
    vt[1] = '{1'b0, 10'd5, 8'd128, 24'd0, 1'b0};
    vt[7] = '{1'b0, 10'd5, 8'd128, 24'd0, 1'b0};
    vt[8] = '{1'b0, 10'd5, 8'd128, 24'd0, 1'b0};

    for (int i = 0; i < 9; i++) begin
      tick(vt[i].p, vt[i].d, vt[i].a, 1'b1);
      check($sformatf("tbl%0d_out", i), out, vt[i].eo);
      check($sformatf("tbl%0d_busy", i), {23'd0, busy}, {23'd0, vt[i].eb});
    end

    // Retrigger at sample 40 of a 100-sample burst with delay=10
    busy_cnt = 0;
    tickc("rt_s0", 1'b1, 10'd100, 8'd200, 1'b1);
    if (busy) busy_cnt++;
    for (int i = 1; i < 40; i++) begin
      tickc($sformatf("rt_s%0d", i), 1'b0, 10'd100, 8'(i * 7 + 3), 1'b1);
      if (busy) busy_cnt++;
    end
    for (int i = 0; i < 10; i++) begin
      tickc($sformatf("rt2_s%0d", i), (i == 0), 10'd10, 8'(255 - i * 11), 1'b1);
      if (busy) busy_cnt++;
    end
    tickc("rt_end", 1'b0, 10'd10, 8'd255, 1'b1);
    if (busy) busy_cnt++;
    check("rt_total_len", 24'(busy_cnt), 24'd50);

    // New start on the edge right after a last sample: no idle gap
    tickc("b2b_a0", 1'b1, 10'd2, 8'd128, 1'b1);
    tickc("b2b_a1", 1'b0, 10'd2, 8'd128, 1'b1);
    tickc("b2b_b0", 1'b1, 10'd3, 8'd64, 1'b1);
    check("b2b_nogap", {23'd0, busy}, 24'd1);
    tickc("b2b_b1", 1'b0, 10'd3, 8'd64, 1'b1);
    tickc("b2b_b2", 1'b0, 10'd3, 8'd64, 1'b1);
    tickc("b2b_idle", 1'b0, 10'd3, 8'd64, 1'b1);

    // Reset at sample 3 of a delay=20 burst, pluck held high through release
    tickc("rm_s0", 1'b1, 10'd20, 8'd128, 1'b1);
    tickc("rm_s1", 1'b0, 10'd20, 8'd128, 1'b1);
    tickc("rm_s2", 1'b0, 10'd20, 8'd128, 1'b1);
    tickc("rm_rst", 1'b1, 10'd20, 8'd128, 1'b0);
    tickc("rm_rel", 1'b1, 10'd8, 8'd128, 1'b1);
    check("rm_seed_sample", out, seed0);
    for (int i = 1; i < 48; i++) begin
      tickc($sformatf("rm_hold%0d", i), 1'b1, 10'd8, 8'd128, 1'b1);
    end
    tickc("hz_low", 1'b0, 10'd8, 8'd0, 1'b1);

    // Pluck held high 200 cycles at amp=0: one 8-sample silent burst
    busy_cnt = 0;
    nz_cnt   = 0;
    for (int i = 0; i < 200; i++) begin
      tickc($sformatf("hz%0d", i), 1'b1, 10'd8, 8'd0, 1'b1);
      if (busy) busy_cnt++;
      if (out != 24'd0) nz_cnt++;
    end
    check("hz_busy_cycles", 24'(busy_cnt), 24'd8);
    check("hz_nonzero_out", 24'(nz_cnt), 24'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
